// File: rtl/nvram_upload_server_if.sv
// hps_io ioctl upload/download bus between the HPS side (master) and the NVRAM image server (slave).
interface nvram_upload_server_if;
    logic        ioctl_upload;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_din, ioctl_wait, ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_din, ioctl_wait, ioctl_upload_req
    );
endinterface

// File: rtl/nvram_upload_server.sv
// Byte-wide NVRAM shadow served over hps_io upload and restored from download.
// Define NVRAM_AUTOSAVE_EN to build dirty tracking, the quiet counter and ioctl_upload_req.
module nvram_upload_server #(
    parameter int unsigned AW       = 8,
    parameter logic [7:0]  NV_INDEX = 8'd4,
    parameter logic [23:0] QUIET    = 24'd5_360_000
) (
    input  logic                  i_clk,
    input  logic                  RESETn,
    input  logic                  cpu_we,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [7:0]            cpu_din,
    output logic                  rst_we,
    output logic [AW-1:0]         rst_addr,
    output logic [7:0]            rst_data,
    nvram_upload_server_if.slave  ioctl
);
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {IDLE, RD, DATA} state_t;
    state_t state;

    logic          up, dn, up_q;
    logic [24:0]   addr_q;
    logic          in_range, restore_wr, snoop;
    logic          cpu_we_q;
    logic [AW-1:0] cpu_addr_q;
    logic [7:0]    cpu_din_q;
    logic [7:0]    rd_data;
    logic          rd_oor;
    logic [7:0]    shadow [DEPTH];

    assign up         = ioctl.ioctl_upload   && (ioctl.ioctl_index == NV_INDEX);
    assign dn         = ioctl.ioctl_download && (ioctl.ioctl_index == NV_INDEX);
    assign in_range   = ioctl.ioctl_addr < 25'(DEPTH);
    assign restore_wr = dn && ioctl.ioctl_wr && in_range;
    assign snoop      = cpu_we && !dn;

    // A CPU write still in flight when a restore byte arrives is dropped: restore owns the image.
    always_ff @(posedge i_clk) begin
        if (restore_wr)
            shadow[ioctl.ioctl_addr[AW-1:0]] <= ioctl.ioctl_dout;
        else if (cpu_we_q)
            shadow[cpu_addr_q] <= cpu_din_q;
        if (state == RD)
            rd_data <= shadow[ioctl.ioctl_addr[AW-1:0]];
    end

    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            state            <= IDLE;
            up_q             <= 1'b0;
            addr_q           <= '0;
            rd_oor           <= 1'b0;
            ioctl.ioctl_wait <= 1'b0;
            ioctl.ioctl_din  <= 8'h00;
            cpu_we_q         <= 1'b0;
            cpu_addr_q       <= '0;
            cpu_din_q        <= '0;
            rst_we           <= 1'b0;
            rst_addr         <= '0;
            rst_data         <= '0;
        end else begin
            up_q       <= up;
            addr_q     <= ioctl.ioctl_addr;
            cpu_we_q   <= snoop;
            cpu_addr_q <= cpu_addr;
            cpu_din_q  <= cpu_din;
            rst_we     <= restore_wr;
            if (restore_wr) begin
                rst_addr <= ioctl.ioctl_addr[AW-1:0];
                rst_data <= ioctl.ioctl_dout;
            end
            if (!up) begin
                state            <= IDLE;
                ioctl.ioctl_wait <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (!up_q || (ioctl.ioctl_addr != addr_q)) begin
                        state            <= RD;
                        ioctl.ioctl_wait <= 1'b1;
                    end
                    RD: begin
                        rd_oor <= !in_range;
                        state  <= DATA;
                    end
                    DATA: begin
                        ioctl.ioctl_din  <= rd_oor ? 8'hFF : rd_data;
                        ioctl.ioctl_wait <= 1'b0;
                        state            <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef NVRAM_AUTOSAVE_EN
    logic        dn_q, dirty, wr_during_up, upload_req;
    logic [23:0] quiet_cnt;

    // Later assignments win: a snooped write in the same cycle as an end-of-transfer keeps dirty set.
    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            dn_q         <= 1'b0;
            dirty        <= 1'b0;
            wr_during_up <= 1'b0;
            quiet_cnt    <= '0;
            upload_req   <= 1'b0;
        end else begin
            dn_q <= dn;
            if (dn_q && !dn)
                dirty <= 1'b0;
            if (up_q && !up) begin
                if (!wr_during_up)
                    dirty <= 1'b0;
                wr_during_up <= 1'b0;
            end
            if (snoop) begin
                dirty <= 1'b1;
                if (up)
                    wr_during_up <= 1'b1;
            end
            if (snoop || (up_q && !up))
                quiet_cnt <= '0;
            else if (dirty && (quiet_cnt != QUIET))
                quiet_cnt <= quiet_cnt + 24'd1;
            if (up && !up_q)
                upload_req <= 1'b0;
            else if (dirty && (quiet_cnt == QUIET) && !up && !dn)
                upload_req <= 1'b1;
        end
    end

    assign ioctl.ioctl_upload_req = upload_req;
`else
    logic unused_quiet;
    assign unused_quiet = ^QUIET;
    assign ioctl.ioctl_upload_req = 1'b0;
`endif
endmodule

// File: tb/tb_nvram_upload_server.sv
// Directed bench for nvram_upload_server; autosave expectations follow NVRAM_AUTOSAVE_EN.
module tb_nvram_upload_server;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       rst_we;
    logic [7:0] rst_addr;
    logic [7:0] rst_data;
    int         passed = 0;
    int         total = 0;
    logic [7:0] img [256];

    nvram_upload_server_if bus ();

    nvram_upload_server #(.AW(8), .NV_INDEX(8'd4), .QUIET(24'd100)) dut (
        .i_clk    (clk),
        .RESETn   (rst_n),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .rst_we   (rst_we),
        .rst_addr (rst_addr),
        .rst_data (rst_data),
        .ioctl    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upload_read(input logic [24:0] a, output logic [7:0] d, output int n);
        bus.ioctl_addr = a;
        n = 0;
        tick();
        while (bus.ioctl_wait && n < 8) begin
            n++;
            tick();
        end
        d = bus.ioctl_din;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        bus.ioctl_upload = 1'b0; bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd4;
        bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
        repeat (3) tick();
        total++; if (bus.ioctl_din !== 8'h00) $display("FAIL reset_din got %h want 00", bus.ioctl_din); else passed++;
        total++; if (bus.ioctl_wait !== 1'b0) $display("FAIL reset_wait got %b want 0", bus.ioctl_wait); else passed++;
        total++; if (bus.ioctl_upload_req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.ioctl_upload_req); else passed++;
        total++; if (rst_we !== 1'b0) $display("FAIL reset_rst_we got %b want 0", rst_we); else passed++;
        total++; if (rst_addr !== 8'h00) $display("FAIL reset_rst_addr got %h want 00", rst_addr); else passed++;
        total++; if (rst_data !== 8'h00) $display("FAIL reset_rst_data got %h want 00", rst_data); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_index_select();
        bus.ioctl_index = 8'd5;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_addr = 25'h3;
        tick(); tick();
        total++; if (bus.ioctl_wait !== 1'b0) $display("FAIL wrong_index_wait got %b want 0", bus.ioctl_wait); else passed++;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index = 8'd4;
        tick(); tick();
    endtask

    task automatic test_snoop_upload();
        logic [7:0] d;
        int n, bad;
        cpu_we = 1'b1; cpu_addr = 8'h10; cpu_din = 8'hA5; tick();
        cpu_addr = 8'hFF; cpu_din = 8'h5A; tick();
        cpu_we = 1'b0; tick();
        bus.ioctl_upload = 1'b1;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            upload_read(25'(a), d, n);
            if (n != 2) bad++;
            img[a] = d;
        end
        total++; if (bad != 0) $display("FAIL snoop_wait_cycles reads_not_2 got %0d want 0", bad); else passed++;
        total++; if (img[16] !== 8'hA5) $display("FAIL snoop_byte16 got %h want a5", img[16]); else passed++;
        total++; if (img[255] !== 8'h5A) $display("FAIL snoop_byte255 got %h want 5a", img[255]); else passed++;
        bus.ioctl_upload = 1'b0;
        tick();
        total++; if (bus.ioctl_wait !== 1'b0) $display("FAIL upload_end_wait got %b want 0", bus.ioctl_wait); else passed++;
        tick();
    endtask

    task automatic test_out_of_range();
        logic [7:0] d;
        int n;
        bus.ioctl_upload = 1'b1;
        upload_read(25'h100, d, n);
        total++; if (d !== 8'hFF) $display("FAIL oor_100_data got %h want ff", d); else passed++;
        total++; if (n != 2) $display("FAIL oor_100_wait got %0d want 2", n); else passed++;
        upload_read(25'h1FFFFFF, d, n);
        total++; if (d !== 8'hFF) $display("FAIL oor_max_data got %h want ff", d); else passed++;
        total++; if (n != 2) $display("FAIL oor_max_wait got %0d want 2", n); else passed++;
        upload_read(25'h0FF, d, n);
        total++; if (d !== 8'h5A) $display("FAIL edge_ff_data got %h want 5a", d); else passed++;
        total++; if (n != 2) $display("FAIL edge_ff_wait got %0d want 2", n); else passed++;
        bus.ioctl_upload = 1'b0;
        tick(); tick();
    endtask

    task automatic test_restore();
        logic [7:0] d, e;
        int n, bad, req_seen;
        bus.ioctl_download = 1'b1;
        bad = 0;
        req_seen = 0;
        for (int a = 0; a < 256; a++) begin
            e = 8'(a) ^ 8'h3C;
            bus.ioctl_addr = 25'(a);
            bus.ioctl_dout = e;
            bus.ioctl_wr = 1'b1;
            tick();
            if (!(rst_we === 1'b1 && rst_addr === 8'(a) && rst_data === e)) bad++;
            bus.ioctl_wr = 1'b0;
            tick();
            if (rst_we !== 1'b0) bad++;
            if (bus.ioctl_upload_req !== 1'b0) req_seen++;
        end
        total++; if (bad != 0) $display("FAIL restore_pulses bad_pulses got %0d want 0", bad); else passed++;
        bus.ioctl_addr = 25'h100; bus.ioctl_dout = 8'h77; bus.ioctl_wr = 1'b1;
        tick();
        total++; if (rst_we !== 1'b0) $display("FAIL restore_discard_rst_we got %b want 0", rst_we); else passed++;
        bus.ioctl_wr = 1'b0;
        cpu_we = 1'b1; cpu_addr = 8'h05; cpu_din = 8'hEE; tick();
        cpu_we = 1'b0; tick();
        bus.ioctl_download = 1'b0;
        repeat (3) tick();
        bus.ioctl_upload = 1'b1;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            upload_read(25'(a), d, n);
            if (n != 2 || d !== (8'(a) ^ 8'h3C)) bad++;
            img[a] = d;
            if (bus.ioctl_upload_req !== 1'b0) req_seen++;
        end
        total++; if (bad != 0) $display("FAIL restore_readback bad_reads got %0d want 0", bad); else passed++;
        total++; if (img[0] !== 8'h3C) $display("FAIL restore_discarded_byte got %h want 3c", img[0]); else passed++;
        total++; if (img[5] !== 8'h39) $display("FAIL restore_cpu_ignored got %h want 39", img[5]); else passed++;
        total++; if (req_seen != 0) $display("FAIL restore_no_req cycles_high got %0d want 0", req_seen); else passed++;
        bus.ioctl_upload = 1'b0;
        tick(); tick();
    endtask

`ifdef NVRAM_AUTOSAVE_EN
    task automatic test_autosave();
        int k;
        cpu_we = 1'b1; cpu_addr = 8'h30; cpu_din = 8'h42; tick();
        cpu_we = 1'b0;
        k = 0;
        while (!bus.ioctl_upload_req && k < 300) begin tick(); k++; end
        total++; if (k != 101) $display("FAIL autosave_latency got %0d want 101", k); else passed++;
        repeat (20) tick();
        total++; if (bus.ioctl_upload_req !== 1'b1) $display("FAIL autosave_hold got %b want 1", bus.ioctl_upload_req); else passed++;
        bus.ioctl_upload = 1'b1; bus.ioctl_addr = 25'h0;
        tick();
        total++; if (bus.ioctl_upload_req !== 1'b0) $display("FAIL autosave_drop_on_up got %b want 0", bus.ioctl_upload_req); else passed++;
        repeat (3) tick();
        bus.ioctl_upload = 1'b0;
        repeat (150) tick();
        total++; if (bus.ioctl_upload_req !== 1'b0) $display("FAIL autosave_clean_after_up got %b want 0", bus.ioctl_upload_req); else passed++;
        cpu_we = 1'b1; tick(); cpu_we = 1'b0;
        k = 0;
        repeat (49) begin tick(); k++; end
        cpu_we = 1'b1; tick(); k++; cpu_we = 1'b0;
        while (!bus.ioctl_upload_req && k < 400) begin tick(); k++; end
        total++; if (k != 151) $display("FAIL autosave_delayed got %0d want 151", k); else passed++;
    endtask

    task automatic test_write_during_upload();
        int k;
        bus.ioctl_upload = 1'b1; bus.ioctl_addr = 25'h40;
        tick();
        total++; if (bus.ioctl_upload_req !== 1'b0) $display("FAIL wdu_drop_on_up got %b want 0", bus.ioctl_upload_req); else passed++;
        cpu_we = 1'b1; cpu_addr = 8'h20; cpu_din = 8'h11; tick();
        cpu_we = 1'b0; tick(); tick();
        bus.ioctl_upload = 1'b0;
        tick();
        k = 0;
        while (!bus.ioctl_upload_req && k < 300) begin tick(); k++; end
        total++; if (k != 101) $display("FAIL wdu_reassert got %0d want 101", k); else passed++;
    endtask
`else
    task automatic test_autosave();
        int seen;
        seen = 0;
        cpu_we = 1'b1; cpu_addr = 8'h30; cpu_din = 8'h42; tick();
        cpu_we = 1'b0;
        repeat (300) begin tick(); if (bus.ioctl_upload_req !== 1'b0) seen++; end
        total++; if (seen != 0) $display("FAIL autosave_off_req cycles_high got %0d want 0", seen); else passed++;
    endtask

    task automatic test_write_during_upload();
        int seen;
        seen = 0;
        bus.ioctl_upload = 1'b1; bus.ioctl_addr = 25'h40;
        tick();
        cpu_we = 1'b1; cpu_addr = 8'h20; cpu_din = 8'h11; tick();
        cpu_we = 1'b0; tick(); tick();
        bus.ioctl_upload = 1'b0;
        repeat (150) begin tick(); if (bus.ioctl_upload_req !== 1'b0) seen++; end
        total++; if (seen != 0) $display("FAIL wdu_off_req cycles_high got %0d want 0", seen); else passed++;
    endtask
`endif

    task automatic test_async_reset();
        logic [7:0] d;
        int n;
        bus.ioctl_upload = 1'b1; bus.ioctl_addr = 25'h10;
        tick();
        total++; if (bus.ioctl_wait !== 1'b1) $display("FAIL areset_pre_wait got %b want 1", bus.ioctl_wait); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.ioctl_wait !== 1'b0) $display("FAIL areset_wait got %b want 0", bus.ioctl_wait); else passed++;
        total++; if (bus.ioctl_din !== 8'h00) $display("FAIL areset_din got %h want 00", bus.ioctl_din); else passed++;
        tick();
        rst_n = 1'b1;
        upload_read(25'h10, d, n);
        total++; if (d !== 8'h2C) $display("FAIL areset_first_read_data got %h want 2c", d); else passed++;
        total++; if (n != 2) $display("FAIL areset_first_read_wait got %0d want 2", n); else passed++;
        bus.ioctl_upload = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_index_select();
        test_snoop_upload();
        test_out_of_range();
        test_restore();
        test_autosave();
        test_write_during_upload();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
